mod_memstage: RTL and testbench
===============================

MOD_MEMSTAGE -- requirements
Module: mod_memstage

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 64, memory address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for a memory response before raising mem_err.

Ports (name, direction, width, meaning); vectors use [0:N-1] numbering, bit 0 is the MSB:
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1) forming the upstream handshake from EX.
REQ-006 The block SHALL have port in_memop, input, 2: 00 none, 01 load, 10 store, 11 illegal (treated as none).
REQ-007 The block SHALL have inputs in_addr (ADDR_W), in_wdata (64), in_alu_result (64), in_alu_ext_result (64), in_pc (64), in_opcode (8), in_twob (1), in_regbyte (4), in_rmbyte (4), in_sim_end (1).
REQ-008 The block SHALL have outputs mem_req (1), mem_we (1), mem_addr (ADDR_W) and mem_wdata (64), plus inputs mem_gnt (1), mem_rvalid (1) and mem_rdata (64), forming the memory port.
REQ-009 The block SHALL have outputs wb_valid (1), wb_pc (64), wb_alu_result (64), wb_alu_ext_result (64), wb_opcode (8), wb_twob (1), wb_regbyte (4), wb_rmbyte (4) and wb_sim_end (1), which form the EX_WB bundle, and input wb_ready (1).
REQ-010 The block SHALL have outputs store_memstage_active (1), high while the bundle held in wb_* is a completed store, and mem_err (1), a sticky timeout flag.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, WAIT and HOLD.
REQ-012 in_ready SHALL be 1 only in IDLE, or in HOLD when wb_ready=1 in the same cycle.
REQ-013 An accepted transfer (in_valid and in_ready) with memop none SHALL latch all fields into wb_*, set wb_valid the next cycle and go to HOLD; latency is 1 cycle.
REQ-014 An accepted load or store SHALL latch the fields, assert mem_req with mem_addr=in_addr the next cycle, set mem_we=1 for a store only, and go to REQ.
REQ-015 In REQ the outputs mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_gnt=1; on mem_gnt the FSM goes to WAIT and mem_req drops.
REQ-016 In WAIT, when mem_rvalid=1, a load SHALL replace wb_alu_result with mem_rdata; a store ignores mem_rdata. The FSM then goes to HOLD with wb_valid=1.
REQ-017 If mem_gnt and mem_rvalid are both 1 in REQ, the transfer SHALL complete directly to HOLD in that cycle.
REQ-018 In HOLD, wb_* SHALL stay stable while wb_ready=0; when wb_ready=1 the FSM goes to IDLE, or accepts a new transfer in the same cycle if in_valid=1 (back-to-back, no bubble).
REQ-019 store_memstage_active SHALL be 1 only in HOLD with a latched store.
REQ-020 A 16-bit wait counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT; at TIMEOUT, mem_err sets and the FSM goes to HOLD with wb_alu_result=0. mem_err clears only on reset.
REQ-021 mem_rvalid outside WAIT/REQ SHALL be ignored.
REQ-022 A latched wb_sim_end=1 SHALL pass through unchanged; the block itself never ends the simulation.

Reset
REQ-023 On reset=1 at a rising edge, the state SHALL be IDLE and all outputs SHALL be 0, including wb_valid, mem_req, mem_err and store_memstage_active; in_ready=1 the cycle after reset deasserts.
REQ-024 A reset during REQ or WAIT SHALL abandon the transaction with no wb_valid pulse, and any later mem_rvalid is ignored.

Verification
REQ-025 ALU op: memop=00, alu_result=0x1234, wb_ready=1 -> wb_valid=1 one cycle later with wb_alu_result=0x1234, and back in IDLE the next cycle.
REQ-026 Load: addr=0x1000, gnt after 2 cycles, rvalid with rdata=0xDEADBEEF 3 cycles later -> mem_req held 2 cycles, wb_alu_result=0xDEADBEEF, wb_regbyte preserved.
REQ-027 Store: memop=10, wdata=0x55 -> mem_we=1, mem_wdata=0x55, then store_memstage_active=1 in HOLD only.
REQ-028 Backpressure: wb_ready=0 for 5 cycles in HOLD -> wb_* stable, in_ready=0; when wb_ready rises with in_valid=1 the next op is accepted in that cycle.
REQ-029 Timeout: TIMEOUT=8, no rvalid -> mem_err=1 after 8 cycles, wb_valid=1 with result 0; reset clears mem_err.
REQ-030 Reset mid-WAIT followed by a late rvalid -> no wb_valid, state IDLE.

Source files
------------

// File: rtl/mod_memstage.sv
// rtl/mod_memstage.sv - MEM pipeline stage: one outstanding memory access between EX and WB
module mod_memstage #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:1]        in_memop,
  input  logic [0:ADDR_W-1] in_addr,
  input  logic [0:63]       in_wdata,
  input  logic [0:63]       in_alu_result,
  input  logic [0:63]       in_alu_ext_result,
  input  logic [0:63]       in_pc,
  input  logic [0:7]        in_opcode,
  input  logic              in_twob,
  input  logic [0:3]        in_regbyte,
  input  logic [0:3]        in_rmbyte,
  input  logic              in_sim_end,
  output logic              mem_req,
  output logic              mem_we,
  output logic [0:ADDR_W-1] mem_addr,
  output logic [0:63]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [0:63]       mem_rdata,
  output logic              wb_valid,
  output logic [0:63]       wb_pc,
  output logic [0:63]       wb_alu_result,
  output logic [0:63]       wb_alu_ext_result,
  output logic [0:7]        wb_opcode,
  output logic              wb_twob,
  output logic [0:3]        wb_regbyte,
  output logic [0:3]        wb_rmbyte,
  output logic              wb_sim_end,
  input  logic              wb_ready,
  output logic              store_memstage_active,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        lat_load;
  logic        lat_store;
  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        timed_out;
  logic        rsp_done;

  // in_ready is held low during reset so nothing can slip in on the release edge.
  always_comb begin
    in_ready = !reset && ((state == IDLE) || (state == HOLD && wb_ready));
  end

  assign accept    = in_valid && in_ready;
  assign is_load   = (in_memop == 2'b01);
  assign is_store  = (in_memop == 2'b10);
  assign timed_out = (wait_cnt + 16'd1) >= TIMEOUT_CNT;
  // A response counts in WAIT, or in REQ only when it coincides with the grant.
  assign rsp_done  = mem_rvalid && ((state == WAIT) || (state == REQ && mem_gnt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      wait_cnt              <= '0;
      lat_load              <= 1'b0;
      lat_store             <= 1'b0;
      mem_req               <= 1'b0;
      mem_we                <= 1'b0;
      mem_addr              <= '0;
      mem_wdata             <= '0;
      mem_err               <= 1'b0;
      wb_valid              <= 1'b0;
      wb_pc                 <= '0;
      wb_alu_result         <= '0;
      wb_alu_ext_result     <= '0;
      wb_opcode             <= '0;
      wb_twob               <= 1'b0;
      wb_regbyte            <= '0;
      wb_rmbyte             <= '0;
      wb_sim_end            <= 1'b0;
      store_memstage_active <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            wb_pc                 <= in_pc;
            wb_alu_result         <= in_alu_result;
            wb_alu_ext_result     <= in_alu_ext_result;
            wb_opcode             <= in_opcode;
            wb_twob               <= in_twob;
            wb_regbyte            <= in_regbyte;
            wb_rmbyte             <= in_rmbyte;
            wb_sim_end            <= in_sim_end;
            lat_load              <= is_load;
            lat_store             <= is_store;
            store_memstage_active <= 1'b0;
            wait_cnt              <= '0;
            if (is_load || is_store) begin
              state     <= REQ;
              wb_valid  <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= in_addr;
              mem_wdata <= in_wdata;
            end else begin
              state    <= HOLD;
              wb_valid <= 1'b1;
            end
          end else if (state == HOLD && wb_ready) begin
            state                 <= IDLE;
            wb_valid              <= 1'b0;
            store_memstage_active <= 1'b0;
          end
        end
        REQ, WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (state == REQ && mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
          if (rsp_done) begin
            if (lat_load) begin
              wb_alu_result <= mem_rdata;
            end
            wb_valid              <= 1'b1;
            store_memstage_active <= lat_store;
            state                 <= HOLD;
          end else if (timed_out) begin
            mem_err       <= 1'b1;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            wb_alu_result <= '0;
            wb_valid      <= 1'b1;
            state         <= HOLD;
          end else if (state == REQ && mem_gnt) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_memstage.sv
// tb/tb_mod_memstage.sv - self-checking bench for mod_memstage with a transaction-level model
module tb_mod_memstage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [0:1]  in_memop;
  logic [0:63] in_addr, in_wdata, in_alu_result, in_alu_ext_result, in_pc;
  logic [0:7]  in_opcode;
  logic        in_twob;
  logic [0:3]  in_regbyte, in_rmbyte;
  logic        in_sim_end;
  logic        mem_req, mem_we;
  logic [0:63] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [0:63] mem_rdata;
  logic        wb_valid;
  logic [0:63] wb_pc, wb_alu_result, wb_alu_ext_result;
  logic [0:7]  wb_opcode;
  logic        wb_twob;
  logic [0:3]  wb_regbyte, wb_rmbyte;
  logic        wb_sim_end;
  logic        wb_ready;
  logic        store_memstage_active;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] addr, wdata, alu, ext, pc, rdata;
    logic [7:0]  opc;
    logic        twob;
    logic [3:0]  rb, rmb;
    logic        se;
    logic [3:0]  gdly, rdly, stall;
  } txn_t;

  mod_memstage #(.ADDR_W(64), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_memop(in_memop), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu_result(in_alu_result), .in_alu_ext_result(in_alu_ext_result),
    .in_pc(in_pc), .in_opcode(in_opcode), .in_twob(in_twob),
    .in_regbyte(in_regbyte), .in_rmbyte(in_rmbyte), .in_sim_end(in_sim_end),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result),
    .wb_alu_ext_result(wb_alu_ext_result), .wb_opcode(wb_opcode), .wb_twob(wb_twob),
    .wb_regbyte(wb_regbyte), .wb_rmbyte(wb_rmbyte), .wb_sim_end(wb_sim_end),
    .wb_ready(wb_ready), .store_memstage_active(store_memstage_active), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Reference model: what WB must see once a transaction has finished.
  function automatic logic [63:0] exp_result(input txn_t t);
    return (t.op == 2'b01) ? t.rdata : t.alu;
  endfunction

  function automatic logic exp_store(input txn_t t);
    return t.op == 2'b10;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.op    = 2'($urandom_range(0, 3));
    t.addr  = {$urandom, $urandom};
    t.wdata = {$urandom, $urandom};
    t.alu   = {$urandom, $urandom};
    t.ext   = {$urandom, $urandom};
    t.pc    = {$urandom, $urandom};
    t.rdata = {$urandom, $urandom};
    t.opc   = 8'($urandom);
    t.twob  = 1'($urandom);
    t.rb    = 4'($urandom);
    t.rmb   = 4'($urandom);
    t.se    = 1'($urandom);
    t.gdly  = 4'($urandom_range(0, 2));
    t.rdly  = 4'($urandom_range(0, 2));
    t.stall = 4'($urandom_range(0, 3));
    return t;
  endfunction

  function automatic txn_t base_txn(input logic [1:0] op, input logic [63:0] addr,
                                    input logic [63:0] wdata, input logic [63:0] alu);
    txn_t t;
    t = rand_txn();
    t.op = op; t.addr = addr; t.wdata = wdata; t.alu = alu;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input txn_t t);
    in_valid = 1'b1; in_memop = t.op; in_addr = t.addr; in_wdata = t.wdata;
    in_alu_result = t.alu; in_alu_ext_result = t.ext; in_pc = t.pc; in_opcode = t.opc;
    in_twob = t.twob; in_regbyte = t.rb; in_rmbyte = t.rmb; in_sim_end = t.se;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_memop = 0; in_addr = 0; in_wdata = 0; in_alu_result = 0;
    in_alu_ext_result = 0; in_pc = 0; in_opcode = 0; in_twob = 0; in_regbyte = 0;
    in_rmbyte = 0; in_sim_end = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; wb_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    in_valid = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({wb_valid, mem_req, mem_we, mem_err, store_memstage_active} !== 5'b0)
      begin errors++; $display("FAIL reset_flags got=%b exp=00000", {wb_valid, mem_req, mem_we, mem_err, store_memstage_active}); end
    checks++; if ({wb_alu_result, wb_pc, mem_addr, mem_wdata} !== 256'b0)
      begin errors++; $display("FAIL reset_data got=%h exp=0", {wb_alu_result, wb_pc, mem_addr, mem_wdata}); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_alu_op();
    txn_t t;
    t = base_txn(2'b00, 64'h0, 64'h0, 64'h1234);
    t.se = 1'b1;
    wb_ready = 1'b1;
    drive(t);
    tick();
    in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_alu_result !== 64'h1234)
      begin errors++; $display("FAIL alu_wb got valid=%b res=%h exp valid=1 res=1234", wb_valid, wb_alu_result); end
    checks++; if (wb_pc !== t.pc || wb_sim_end !== 1'b1 || wb_regbyte !== t.rb || mem_req !== 1'b0)
      begin errors++; $display("FAIL alu_fields got pc=%h se=%b rb=%h req=%b exp pc=%h se=1 rb=%h req=0", wb_pc, wb_sim_end, wb_regbyte, mem_req, t.pc, t.rb); end
    tick();
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL alu_idle got valid=%b in_ready=%b exp 0 1", wb_valid, in_ready); end
    wb_ready = 1'b0;
  endtask

  task automatic test_load();
    txn_t t;
    t = base_txn(2'b01, 64'h1000, 64'h0, 64'h9999);
    t.rb = 4'hA;
    drive(t);
    tick();
    in_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h1000)
      begin errors++; $display("FAIL load_req1 got req=%b we=%b addr=%h exp 1 0 1000", mem_req, mem_we, mem_addr); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000 || wb_valid !== 1'b0)
      begin errors++; $display("FAIL load_req2 got req=%b addr=%h valid=%b exp 1 1000 0", mem_req, mem_addr, wb_valid); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0)
      begin errors++; $display("FAIL load_gnt got req=%b valid=%b exp 0 0", mem_req, wb_valid); end
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_alu_result !== 64'hDEADBEEF || wb_regbyte !== 4'hA)
      begin errors++; $display("FAIL load_done got valid=%b res=%h rb=%h exp 1 deadbeef a", wb_valid, wb_alu_result, wb_regbyte); end
    checks++; if (store_memstage_active !== 1'b0)
      begin errors++; $display("FAIL load_store_active got=%b exp=0", store_memstage_active); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_store();
    txn_t t;
    t = base_txn(2'b10, 64'h2000, 64'h55, 64'h77);
    drive(t);
    tick();
    in_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 64'h55 || store_memstage_active !== 1'b0)
      begin errors++; $display("FAIL store_req got req=%b we=%b wd=%h sa=%b exp 1 1 55 0", mem_req, mem_we, mem_wdata, store_memstage_active); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_alu_result !== 64'h77 || store_memstage_active !== 1'b1)
      begin errors++; $display("FAIL store_done got valid=%b res=%h sa=%b exp 1 77 1", wb_valid, wb_alu_result, store_memstage_active); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (store_memstage_active !== 1'b0 || wb_valid !== 1'b0)
      begin errors++; $display("FAIL store_release got sa=%b valid=%b exp 0 0", store_memstage_active, wb_valid); end
  endtask

  task automatic test_backpressure();
    txn_t a, b;
    int bad;
    a = base_txn(2'b00, 64'h0, 64'h0, 64'hA1A1);
    b = base_txn(2'b00, 64'h0, 64'h0, 64'hB2B2);
    drive(a);
    tick();
    drive(b);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_valid !== 1'b1 || wb_alu_result !== a.alu || wb_pc !== a.pc || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0)
      begin errors++; $display("FAIL bp_stable got bad_cycles=%0d exp=0 (res=%h)", bad, wb_alu_result); end
    wb_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_alu_result !== b.alu || wb_pc !== b.pc)
      begin errors++; $display("FAIL bp_next got valid=%b res=%h exp 1 %h", wb_valid, wb_alu_result, b.alu); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    txn_t s, l;
    s = base_txn(2'b10, 64'h3000, 64'h1111, 64'h2222);
    l = base_txn(2'b01, 64'h4000, 64'h0, 64'h3333);
    drive(s);
    tick();
    in_valid = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    drive(l);
    wb_ready = 1'b1;
    tick();
    in_valid = 1'b0; wb_ready = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h4000 || mem_we !== 1'b0 || wb_valid !== 1'b0 || store_memstage_active !== 1'b0)
      begin errors++; $display("FAIL b2b_accept got req=%b addr=%h we=%b valid=%b sa=%b exp 1 4000 0 0 0", mem_req, mem_addr, mem_we, wb_valid, store_memstage_active); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = l.rdata;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_alu_result !== exp_result(l))
      begin errors++; $display("FAIL b2b_load got valid=%b res=%h exp 1 %h", wb_valid, wb_alu_result, exp_result(l)); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_timeout();
    txn_t t, a;
    t = base_txn(2'b01, 64'h5000, 64'h0, 64'hAAAA);
    drive(t);
    tick();
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 2; i <= 7; i++) tick();
    checks++; if (mem_err !== 1'b0 || wb_valid !== 1'b0)
      begin errors++; $display("FAIL timeout_early got err=%b valid=%b exp 0 0", mem_err, wb_valid); end
    tick();
    checks++; if (mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_alu_result !== 64'h0 || mem_req !== 1'b0)
      begin errors++; $display("FAIL timeout_hit got err=%b valid=%b res=%h req=%b exp 1 1 0 0", mem_err, wb_valid, wb_alu_result, mem_req); end
    wb_ready = 1'b1;
    tick();
    a = base_txn(2'b00, 64'h0, 64'h0, 64'h42);
    drive(a);
    tick();
    in_valid = 1'b0;
    tick();
    wb_ready = 1'b0;
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", mem_err); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_reset got=%b exp=0", mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    txn_t t;
    int bad;
    t = base_txn(2'b01, 64'h6000, 64'h0, 64'h5151);
    drive(t);
    tick();
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_rvalid = 1'b0;
      if (wb_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0)
      begin errors++; $display("FAIL reset_wait got bad_cycles=%0d exp=0 (valid=%b)", bad, wb_valid); end
    checks++; if (wb_alu_result !== 64'h0)
      begin errors++; $display("FAIL reset_wait_data got=%h exp=0", wb_alu_result); end
  endtask

  task automatic test_random();
    txn_t t;
    int bad;
    for (int n = 0; n < 40; n++) begin
      t = rand_txn();
      drive(t);
      tick();
      in_valid = 1'b0;
      if (t.op == 2'b01 || t.op == 2'b10) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== t.addr || mem_we !== exp_store(t))
          begin errors++; $display("FAIL rnd_req[%0d] got req=%b addr=%h we=%b exp 1 %h %b", n, mem_req, mem_addr, mem_we, t.addr, exp_store(t)); end
        for (int i = 0; i < int'(t.gdly); i++) tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== t.addr || (exp_store(t) && mem_wdata !== t.wdata))
          begin errors++; $display("FAIL rnd_hold_req[%0d] got req=%b addr=%h wd=%h", n, mem_req, mem_addr, mem_wdata); end
        mem_gnt = 1'b1;
        if (t.rdly == 0) begin mem_rvalid = 1'b1; mem_rdata = t.rdata; end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (t.rdly != 0) begin
          for (int i = 1; i < int'(t.rdly); i++) tick();
          mem_rvalid = 1'b1; mem_rdata = t.rdata;
          tick();
          mem_rvalid = 1'b0;
        end
      end
      checks++; if (wb_valid !== 1'b1 || wb_alu_result !== exp_result(t) || store_memstage_active !== exp_store(t))
        begin errors++; $display("FAIL rnd_result[%0d] op=%b got valid=%b res=%h sa=%b exp 1 %h %b", n, t.op, wb_valid, wb_alu_result, store_memstage_active, exp_result(t), exp_store(t)); end
      checks++; if ({wb_pc, wb_alu_ext_result, wb_opcode, wb_twob, wb_regbyte, wb_rmbyte, wb_sim_end} !== {t.pc, t.ext, t.opc, t.twob, t.rb, t.rmb, t.se})
        begin errors++; $display("FAIL rnd_fields[%0d] got pc=%h ext=%h opc=%h exp pc=%h ext=%h opc=%h", n, wb_pc, wb_alu_ext_result, wb_opcode, t.pc, t.ext, t.opc); end
      bad = 0;
      for (int i = 0; i < int'(t.stall); i++) begin
        tick();
        if (wb_valid !== 1'b1 || wb_alu_result !== exp_result(t) || in_ready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd_stall[%0d] got bad_cycles=%0d exp=0", n, bad); end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      checks++; if (wb_valid !== 1'b0 || store_memstage_active !== 1'b0)
        begin errors++; $display("FAIL rnd_release[%0d] got valid=%b sa=%b exp 0 0", n, wb_valid, store_memstage_active); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
